// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Optional memory-wait timeout is enabled by defining MC_TIMEOUT_EN.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rstIn,
  input  logic [6:0] IW2Contr,
  input  logic       memReady,
  output logic       LIR,
  output logic       LPC,
  output logic       rd1,
  output logic       rd2,
  output logic       wr_contr,
  output logic       Lflag_contr,
  output logic       isJumpInstr,
  output logic       isCallInstr,
  output logic       rdM,
  output logic       wrM_contr,
  output logic       PCrst,
  output logic [1:0] selM1,
  output logic [1:0] selM2,
  output logic [1:0] selM3,
  output logic [1:0] fnSel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  // state  | meaning
  // FETCH  | read instruction memory, load IR on memReady
  // DECODE | classify opcode into the class register
  // EXEC   | ALU / address / branch step
  // MEM    | data memory access for LA and STA
  // WB     | register/flag write-back and PC load
  // TRAP   | illegal opcode or memory timeout, left only by reset
  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b101
  } state_t;

  typedef enum logic [3:0] {
    C_ALUI, C_ALUR, C_MNSI, C_MNSR, C_CMP, C_LI, C_LR,
    C_LA, C_STA, C_JMP, C_JAL, C_JR, C_ILL, C_TMO
  } cls_t;

  state_t state_q;
  cls_t   cls_q;
  cls_t   cls_dec;
  cls_t   cls_eff;
  logic   tmo_hit;

  always_comb begin
    cls_dec = C_ILL;
    casez (IW2Contr)
      7'b00??0??: cls_dec = C_ALUI;
      7'b00??1??: cls_dec = C_ALUR;
      7'b01000??: cls_dec = C_MNSI;
      7'b01001??: cls_dec = C_MNSR;
      7'b0101???: cls_dec = C_CMP;
      7'b100?00?: cls_dec = C_LI;
      7'b100?01?: cls_dec = C_LR;
      7'b100?10?: cls_dec = C_LA;
      7'b101????: cls_dec = C_STA;
      7'b110????: cls_dec = C_JMP;
      7'b1110???: cls_dec = C_JAL;
      7'b1111???: cls_dec = C_JR;
      default:    cls_dec = C_ILL;
    endcase
  end

`ifdef MC_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       wait_w;

  assign wait_w  = ((state_q == FETCH) || (state_q == MEM)) && !memReady;
  assign tmo_hit = wait_w && (cnt_q == 4'd15);

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn)                 cnt_q <= 4'd0;
    else if (wait_w && !tmo_hit) cnt_q <= cnt_q + 4'd1;
    else                        cnt_q <= 4'd0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Timeout traps reuse the class register (C_TMO) so the trap cause needs no extra flop.
  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      state_q <= FETCH;
      cls_q   <= C_ILL;
    end else begin
      case (state_q)
        FETCH: begin
          if (tmo_hit) begin
            state_q <= TRAP;
            cls_q   <= C_TMO;
          end else if (memReady) begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          cls_q   <= cls_dec;
          state_q <= EXEC;
        end
        EXEC: begin
          case (cls_q)
            C_LA, C_STA:  state_q <= MEM;
            C_JMP, C_JR:  state_q <= FETCH;
            C_ILL, C_TMO: state_q <= TRAP;
            default:      state_q <= WB;
          endcase
        end
        MEM: begin
          if (tmo_hit) begin
            state_q <= TRAP;
            cls_q   <= C_TMO;
          end else if (memReady) begin
            state_q <= (cls_q == C_STA) ? FETCH : WB;
          end
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Register reads in DECODE must use the opcode directly; the class register loads at its end.
  assign cls_eff = (state_q == DECODE) ? cls_dec : cls_q;
  assign state   = state_q;
  assign PCrst   = rstIn;

  always_comb begin
    LIR         = 1'b0;
    LPC         = 1'b0;
    rd1         = 1'b0;
    rd2         = 1'b0;
    wr_contr    = 1'b0;
    Lflag_contr = 1'b0;
    isJumpInstr = 1'b0;
    isCallInstr = 1'b0;
    rdM         = 1'b0;
    wrM_contr   = 1'b0;
    selM1       = 2'b11;
    selM2       = 2'b11;
    selM3       = 2'b11;
    fnSel       = 2'b11;
    illegal     = 1'b0;
    timeout     = 1'b0;
    if (rstIn) begin
      if (state_q inside {DECODE, EXEC, MEM}) begin
        rd2 = cls_eff inside {C_ALUI, C_ALUR, C_MNSI, C_MNSR, C_CMP, C_STA, C_JR};
        rd1 = cls_eff inside {C_ALUR, C_MNSR, C_LR, C_LA, C_STA};
      end
      if (state_q inside {EXEC, MEM, WB}) begin
        case (cls_q)
          C_ALUI, C_MNSI: begin selM1 = 2'b10; selM2 = 2'b01; fnSel = 2'b00; selM3 = 2'b10; end
          C_ALUR, C_MNSR: begin selM1 = 2'b01; selM2 = 2'b01; fnSel = 2'b00; selM3 = 2'b10; end
          C_CMP:          begin selM1 = 2'b11; selM2 = 2'b01; fnSel = 2'b01; selM3 = 2'b10; end
          C_LI:           begin selM1 = 2'b11; selM2 = 2'b10; fnSel = 2'b01; selM3 = 2'b10; end
          C_LR:           begin selM1 = 2'b11; selM2 = 2'b00; fnSel = 2'b01; selM3 = 2'b10; end
          C_LA:           begin selM1 = 2'b01; selM2 = 2'b10; fnSel = 2'b10; selM3 = 2'b01; end
          C_STA:          begin selM1 = 2'b01; selM2 = 2'b10; fnSel = 2'b10; selM3 = 2'b11; end
          C_JMP:          begin selM1 = 2'b00; selM2 = 2'b10; fnSel = 2'b10; selM3 = 2'b11; end
          C_JAL:          begin selM1 = 2'b00; selM2 = 2'b10; fnSel = 2'b10; selM3 = 2'b00; end
          C_JR:           begin selM1 = 2'b11; selM2 = 2'b01; fnSel = 2'b01; selM3 = 2'b11; end
          default:        ;
        endcase
      end
      case (state_q)
        FETCH: begin
          rdM = 1'b1;
          LIR = memReady;
        end
        EXEC: begin
          if (cls_q == C_JMP) begin
            isJumpInstr = 1'b1;
            LPC         = 1'b1;
          end else if (cls_q == C_JR) begin
            isCallInstr = 1'b1;
            LPC         = 1'b1;
          end
        end
        MEM: begin
          if (cls_q == C_LA) rdM = 1'b1;
          if (cls_q == C_STA) begin
            wrM_contr = 1'b1;
            LPC       = memReady;
          end
        end
        WB: begin
          wr_contr    = !(cls_q inside {C_MNSI, C_MNSR, C_STA});
          Lflag_contr = cls_q inside {C_ALUI, C_ALUR, C_MNSI, C_MNSR, C_CMP};
          isCallInstr = (cls_q == C_JAL);
          LPC         = (cls_q != C_JAL);
        end
        TRAP: begin
          illegal = (cls_q != C_TMO);
`ifdef MC_TIMEOUT_EN
          timeout = (cls_q == C_TMO);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
